// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - microcode step counter, flag latch and control-word decode for the 8-bit CPU
module control_sequencer #(
  // The microcode uses steps 0..4, so this must stay at 3 or more.
  parameter int STEP_W = 3
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [3:0]        instruction,
  input  logic              carry_in,
  input  logic              zero_in,
  output logic [15:0]       ctrl,
  output logic [STEP_W-1:0] step,
  output logic [1:0]        flags,
  output logic              halted
);

  localparam logic [STEP_W-1:0] T0 = STEP_W'(0);
  localparam logic [STEP_W-1:0] T1 = STEP_W'(1);
  localparam logic [STEP_W-1:0] T2 = STEP_W'(2);
  localparam logic [STEP_W-1:0] T3 = STEP_W'(3);
  localparam logic [STEP_W-1:0] T4 = STEP_W'(4);

  localparam logic [3:0] OP_LDA = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_STA = 4'b0100;
  localparam logic [3:0] OP_LDI = 4'b0101;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_JC  = 4'b0111;
  localparam logic [3:0] OP_JZ  = 4'b1000;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // Control words, bit order: hlt mi ri ro io ii ai ao eo su bi oi ce co j fi
  localparam logic [15:0] CW_FETCH0  = 16'h4004; // co|mi
  localparam logic [15:0] CW_FETCH1  = 16'h1408; // ro|ii|ce
  localparam logic [15:0] CW_ADDR    = 16'h4800; // io|mi
  localparam logic [15:0] CW_LOAD_A  = 16'h1200; // ro|ai
  localparam logic [15:0] CW_LOAD_B  = 16'h1020; // ro|bi
  localparam logic [15:0] CW_SUM     = 16'h0281; // eo|ai|fi
  localparam logic [15:0] CW_DIFF    = 16'h02C1; // eo|ai|su|fi
  localparam logic [15:0] CW_STORE   = 16'h2100; // ao|ri
  localparam logic [15:0] CW_IMM     = 16'h0A00; // io|ai
  localparam logic [15:0] CW_JUMP    = 16'h0802; // io|j
  localparam logic [15:0] CW_OUT     = 16'h0110; // ao|oi
  localparam logic [15:0] CW_HALT    = 16'h8000; // hlt

  logic [STEP_W-1:0] r_step;
  logic [1:0]        r_flags;
  logic [15:0]       w_ctrl;
  logic              w_last;
  logic              w_hold;

  // Decode (step, opcode, flags) into the control word and mark each opcode's final step
  always_comb begin
    w_ctrl = '0;
    w_last = 1'b0;
    case (r_step)
      T0: w_ctrl = CW_FETCH0;
      T1: w_ctrl = CW_FETCH1;
      T2: begin
        w_last = 1'b1;
        case (instruction)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            w_ctrl = CW_ADDR;
            w_last = 1'b0;
          end
          OP_LDI: w_ctrl = CW_IMM;
          OP_JMP: w_ctrl = CW_JUMP;
          OP_JC:  w_ctrl = r_flags[1] ? CW_JUMP : 16'h0000;
          OP_JZ:  w_ctrl = r_flags[0] ? CW_JUMP : 16'h0000;
          OP_OUT: w_ctrl = CW_OUT;
          OP_HLT: w_ctrl = CW_HALT;
          default: w_ctrl = 16'h0000;
        endcase
      end
      T3: begin
        w_last = 1'b1;
        case (instruction)
          OP_LDA: w_ctrl = CW_LOAD_A;
          OP_ADD, OP_SUB: begin
            w_ctrl = CW_LOAD_B;
            w_last = 1'b0;
          end
          OP_STA: w_ctrl = CW_STORE;
          default: w_ctrl = 16'h0000;
        endcase
      end
      T4: begin
        w_last = 1'b1;
        case (instruction)
          OP_ADD:  w_ctrl = CW_SUM;
          OP_SUB:  w_ctrl = CW_DIFF;
          default: w_ctrl = 16'h0000;
        endcase
      end
      // Unreachable steps fall back to fetch on the next edge.
      default: w_last = 1'b1;
    endcase
  end

  // HLT parks the counter at T2; only clr releases it.
  assign w_hold = (r_step == T2) && (instruction == OP_HLT);

  // Advance the T-state counter, wrapping to fetch after each opcode's last step
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_step <= T0;
    end else if (w_hold) begin
      r_step <= r_step;
    end else if (w_last) begin
      r_step <= T0;
    end else begin
      r_step <= r_step + T1;
    end
  end

  // Capture ALU carry/zero only on steps that assert fi
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_flags <= 2'b00;
    end else if (w_ctrl[0]) begin
      r_flags <= {carry_in, zero_in};
    end
  end

  assign ctrl   = w_ctrl;
  assign step   = r_step;
  assign flags  = r_flags;
  assign halted = w_ctrl[15];

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed self-checking bench for control_sequencer
module tb_control_sequencer;

  logic        clk;
  logic        clr;
  logic [3:0]  instruction;
  logic        carry_in;
  logic        zero_in;
  logic [15:0] ctrl;
  logic [2:0]  step;
  logic [1:0]  flags;
  logic        halted;

  int n_checks = 0;
  int n_errors = 0;

  control_sequencer #(.STEP_W(3)) dut (
    .clk         (clk),
    .clr         (clr),
    .instruction (instruction),
    .carry_in    (carry_in),
    .zero_in     (zero_in),
    .ctrl        (ctrl),
    .step        (step),
    .flags       (flags),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge with the DUT at T0; checks ctrl/step for n cycles.
  task automatic run_op(input string tag, input logic [3:0] op, input int n,
                        input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2,
                        input logic [15:0] e3, input logic [15:0] e4);
    logic [15:0] exp_cw [5];
    exp_cw[0] = e0; exp_cw[1] = e1; exp_cw[2] = e2; exp_cw[3] = e3; exp_cw[4] = e4;
    instruction = op;
    for (int i = 0; i < n; i++) begin
      #1;
      check($sformatf("%s ctrl T%0d", tag, i), {16'h0, ctrl}, {16'h0, exp_cw[i]});
      check($sformatf("%s step T%0d", tag, i), {29'h0, step}, i);
      @(negedge clk);
    end
    #1;
    check($sformatf("%s back to T0", tag), {29'h0, step}, 0);
  endtask

  initial begin
    clr = 1'b1;
    instruction = 4'h0;
    carry_in = 1'b0;
    zero_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("reset step",   {29'h0, step}, 0);
    check("reset ctrl",   {16'h0, ctrl}, 32'h4004);
    check("reset flags",  {30'h0, flags}, 0);
    check("reset halted", {31'h0, halted}, 0);
    @(negedge clk);
    clr = 1'b0;
    #1;
    check("post-release ctrl", {16'h0, ctrl}, 32'h4004);

    // Opcode noise during fetch must not leak into ctrl.
    instruction = 4'hF;
    #1;
    check("T0 ignores opcode", {16'h0, ctrl}, 32'h4004);
    @(negedge clk);
    instruction = 4'h3;
    #1;
    check("T1 ignores opcode", {16'h0, ctrl}, 32'h1408);
    check("T1 step", {29'h0, step}, 1);
    instruction = 4'h1;
    @(negedge clk);
    #1;
    check("LDA T2 ctrl", {16'h0, ctrl}, 32'h4800);
    @(negedge clk);
    #1;
    check("LDA T3 ctrl", {16'h0, ctrl}, 32'h1200);
    @(negedge clk);
    #1;
    check("LDA wraps", {29'h0, step}, 0);

    run_op("LDA", 4'h1, 4, 16'h4004, 16'h1408, 16'h4800, 16'h1200, 16'h0);

    carry_in = 1'b1; zero_in = 1'b1;
    run_op("ADD11", 4'h2, 5, 16'h4004, 16'h1408, 16'h4800, 16'h1020, 16'h0281);
    check("flags after ADD11", {30'h0, flags}, 2'b11);

    // Abandon an ADD at T3 with an asynchronous clear.
    instruction = 4'h2;
    carry_in = 1'b0; zero_in = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("mid-ADD T3 ctrl", {16'h0, ctrl}, 32'h1020);
    clr = 1'b1;
    #1;
    check("async clr step",  {29'h0, step}, 0);
    check("async clr ctrl",  {16'h0, ctrl}, 32'h4004);
    check("async clr flags", {30'h0, flags}, 0);
    @(negedge clk);
    clr = 1'b0;

    carry_in = 1'b1; zero_in = 1'b0;
    run_op("SUB10", 4'h3, 5, 16'h4004, 16'h1408, 16'h4800, 16'h1020, 16'h02C1);
    check("flags after SUB10", {30'h0, flags}, 2'b10);

    carry_in = 1'b0; zero_in = 1'b1;
    run_op("JC taken", 4'h7, 3, 16'h4004, 16'h1408, 16'h0802, 16'h0, 16'h0);
    run_op("JZ untaken", 4'h8, 3, 16'h4004, 16'h1408, 16'h0000, 16'h0, 16'h0);
    run_op("NOP", 4'h0, 3, 16'h4004, 16'h1408, 16'h0000, 16'h0, 16'h0);
    for (int op = 9; op <= 13; op++) begin
      run_op($sformatf("unused%0d", op), 4'(op), 3, 16'h4004, 16'h1408, 16'h0000, 16'h0, 16'h0);
    end
    check("flags held", {30'h0, flags}, 2'b10);

    carry_in = 1'b0; zero_in = 1'b1;
    run_op("ADD01", 4'h2, 5, 16'h4004, 16'h1408, 16'h4800, 16'h1020, 16'h0281);
    check("flags after ADD01", {30'h0, flags}, 2'b01);
    run_op("JZ taken", 4'h8, 3, 16'h4004, 16'h1408, 16'h0802, 16'h0, 16'h0);
    run_op("JC untaken", 4'h7, 3, 16'h4004, 16'h1408, 16'h0000, 16'h0, 16'h0);

    run_op("STA", 4'h4, 4, 16'h4004, 16'h1408, 16'h4800, 16'h2100, 16'h0);
    run_op("LDI", 4'h5, 3, 16'h4004, 16'h1408, 16'h0A00, 16'h0, 16'h0);
    run_op("JMP", 4'h6, 3, 16'h4004, 16'h1408, 16'h0802, 16'h0, 16'h0);
    run_op("OUT", 4'hE, 3, 16'h4004, 16'h1408, 16'h0110, 16'h0, 16'h0);

    // HLT parks at T2 until clr.
    instruction = 4'hF;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      #1;
      check($sformatf("HLT ctrl c%0d", i), {16'h0, ctrl}, 32'h8000);
      check($sformatf("HLT step c%0d", i), {29'h0, step}, 2);
      check($sformatf("HLT halted c%0d", i), {31'h0, halted}, 1);
      @(negedge clk);
    end
    clr = 1'b1;
    #1;
    check("HLT clr step",   {29'h0, step}, 0);
    check("HLT clr ctrl",   {16'h0, ctrl}, 32'h4004);
    check("HLT clr halted", {31'h0, halted}, 0);
    @(negedge clk);
    clr = 1'b0;
    #1;
    check("restart T0", {16'h0, ctrl}, 32'h4004);
    @(negedge clk);
    #1;
    check("restart T1", {16'h0, ctrl}, 32'h1408);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
